uart_boot_loader: RTL and testbench

- Sits directly downstream of the UART receiver and upstream of the single-cycle core's instruction memory.
- Consumes received bytes, parses a framed program image, assembles little-endian 32-bit words and writes them sequentially into instruction memory.
- Holds the core in reset until a complete, valid image has been written, then releases it.

---
 rtl/uart_boot_loader_if.sv | 30 +++
 rtl/uart_boot_loader.sv | 188 ++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_if.sv
// Byte-stream input from the UART receiver, instruction-memory write port and boot status.
// Loader side drives the write port and status; the environment side drives the byte strobe.
// No backpressure: rx_valid is a one-cycle strobe that the loader always accepts.
interface uart_boot_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  core_hold;
    logic                  boot_done;
    logic                  boot_error;
    logic [ADDR_WIDTH:0]   words_loaded;

    // Loader side
    modport master (
        input  rx_valid, rx_data,
        output imem_we, imem_addr, imem_wdata,
        output core_hold, boot_done, boot_error, words_loaded
    );

    // UART / memory / core side
    modport slave (
        output rx_valid, rx_data,
        input  imem_we, imem_addr, imem_wdata,
        input  core_hold, boot_done, boot_error, words_loaded
    );
endinterface

// File: rtl/uart_boot_loader.sv
// Parses SYNC/LEN/words[/CHK] byte frames into little-endian 32-bit instruction-memory writes; optional macro BOOT_CHECKSUM_EN adds the trailing XOR checksum byte.
// Latency: a word is written the cycle after its 4th byte; status flags update one cycle after the deciding byte/write.
// Backpressure: none; every rx_valid is accepted in its own cycle, write strobes never stall byte intake.
module uart_boot_loader #(
    parameter int          ADDR_WIDTH     = 10,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 2700000
) (
    input  logic               clk,
    input  logic               reset,
    uart_boot_loader_if.master bus
);
    localparam int MAX_WORDS = 2 ** ADDR_WIDTH;
    localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
    // Counter value from which the next idle cycle lands on TIMEOUT_CYCLES-1 and aborts the frame.
    localparam logic [TW-1:0]       TMO_LAST = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [ADDR_WIDTH:0] WL_ONE   = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
`ifdef BOOT_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state;
    logic [7:0]            len_lo;
    logic [ADDR_WIDTH:0]   len;
    logic [1:0]            byte_idx;
    logic [23:0]           word_sr;
    logic [TW-1:0]         tmo_cnt;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]            checksum;
`endif

    logic [16:0]           len_full;
    logic                  last_word;
    logic                  timed;

    // Decode helpers: full LEN as it completes, last-word detect, and which states run the idle timer.
    always_comb begin
        len_full  = {1'b0, bus.rx_data, len_lo};
        last_word = ((bus.words_loaded + WL_ONE) == len);
        timed     = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA)
`ifdef BOOT_CHECKSUM_EN
                    || (state == S_CHECK)
`endif
                    ;
    end

    // Frame parser, word assembler, idle timeout and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            len_lo           <= '0;
            len              <= '0;
            byte_idx         <= '0;
            word_sr          <= '0;
            tmo_cnt          <= '0;
`ifdef BOOT_CHECKSUM_EN
            checksum         <= '0;
`endif
            bus.imem_we      <= 1'b0;
            bus.imem_addr    <= '0;
            bus.imem_wdata   <= '0;
            bus.core_hold    <= 1'b1;
            bus.boot_done    <= 1'b0;
            bus.boot_error   <= 1'b0;
            bus.words_loaded <= '0;
        end else begin
            bus.imem_we <= 1'b0;

            // Idle timer: any byte restarts it; a stalled frame is aborted.
            if (timed) begin
                if (bus.rx_valid) begin
                    tmo_cnt <= '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_cnt        <= '0;
                    state          <= S_ERROR;
                    bus.boot_error <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                        state <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (bus.rx_valid) begin
                        len_lo <= bus.rx_data;
                        state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (bus.rx_valid) begin
                        len              <= len_full[ADDR_WIDTH:0];
                        byte_idx         <= '0;
                        bus.words_loaded <= '0;
`ifdef BOOT_CHECKSUM_EN
                        checksum         <= '0;
`endif
                        if (len_full > 17'(MAX_WORDS)) begin
                            state          <= S_ERROR;
                            bus.boot_error <= 1'b1;
                        end else if (len_full == 17'd0) begin
`ifdef BOOT_CHECKSUM_EN
                            state          <= S_CHECK;
`else
                            state          <= S_DONE;
                            bus.core_hold  <= 1'b0;
                            bus.boot_done  <= 1'b1;
`endif
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (bus.rx_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        word_sr  <= {bus.rx_data, word_sr[23:8]};
`ifdef BOOT_CHECKSUM_EN
                        checksum <= checksum ^ bus.rx_data;
`endif
                        if (byte_idx == 2'd3) begin
                            bus.imem_we      <= 1'b1;
                            bus.imem_wdata   <= {bus.rx_data, word_sr};
                            bus.imem_addr    <= bus.words_loaded[ADDR_WIDTH-1:0];
                            bus.words_loaded <= bus.words_loaded + WL_ONE;
                        end
                    end
`ifdef BOOT_CHECKSUM_EN
                    // Move to CHECK right away so a CHK byte arriving during the write is not missed.
                    if (bus.rx_valid && byte_idx == 2'd3 && last_word) begin
                        state <= S_CHECK;
                    end
`else
                    // Release the core once the final write strobe has been issued.
                    if (bus.imem_we && bus.words_loaded == len) begin
                        state          <= S_DONE;
                        bus.core_hold  <= 1'b0;
                        bus.boot_done  <= 1'b1;
                        bus.boot_error <= 1'b0;
                    end
`endif
                end
`ifdef BOOT_CHECKSUM_EN
                S_CHECK: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == checksum) begin
                            state         <= S_DONE;
                            bus.core_hold <= 1'b0;
                            bus.boot_done <= 1'b1;
                        end else begin
                            state          <= S_ERROR;
                            bus.boot_error <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE: begin
                end
                S_ERROR: begin
                    // Written memory is left intact; a new SYNC starts a fresh frame.
                    if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                        state            <= S_LEN_LO;
                        bus.boot_error   <= 1'b0;
                        bus.words_loaded <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboarded bench for uart_boot_loader (ADDR_WIDTH=4, TIMEOUT_CYCLES=100).
// Stimulus pushes expected memory writes; a negedge monitor pops and compares every imem_we pulse.
// Status flags are compared directly by the stimulus process at fixed points.
module tb_uart_boot_loader;
    localparam int AW = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    wr_t  exp_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] ck;

    uart_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

    uart_boot_loader #(
        .ADDR_WIDTH(AW),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%08h with no write expected",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(bus.imem_addr), 32'(e.addr));
                check("write_data", bus.imem_wdata, e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_all();
        foreach (tx_q[i]) send_byte(tx_q[i]);
        tx_q.delete();
    endtask

    task automatic hdr(input logic [15:0] len);
        ck = 8'h00;
        tx_q.push_back(8'hA5);
        tx_q.push_back(len[7:0]);
        tx_q.push_back(len[15:8]);
    endtask

    task automatic word(input logic [AW-1:0] addr, input logic [31:0] w, input bit expect_wr);
        for (int i = 0; i < 4; i++) begin
            tx_q.push_back(w[8*i +: 8]);
            ck = ck ^ w[8*i +: 8];
        end
        if (expect_wr) exp_q.push_back('{addr: addr, data: w});
    endtask

    task automatic chk_byte(input logic [7:0] c);
`ifdef BOOT_CHECKSUM_EN
        tx_q.push_back(c);
`else
        if (c == 8'h00) tx_q.delete(tx_q.size());
`endif
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"},    32'(bus.imem_we), 32'd0);
        check({tag, "_addr"},  32'(bus.imem_addr), 32'd0);
        check({tag, "_wdata"}, bus.imem_wdata, 32'd0);
        check({tag, "_hold"},  32'(bus.core_hold), 32'd1);
        check({tag, "_done"},  32'(bus.boot_done), 32'd0);
        check({tag, "_err"},   32'(bus.boot_error), 32'd0);
        check({tag, "_words"}, 32'(bus.words_loaded), 32'd0);
    endtask

    task automatic check_status(input string tag, input logic hold, input logic done,
                                input logic err, input int words);
        check({tag, "_hold"},  32'(bus.core_hold), 32'(hold));
        check({tag, "_done"},  32'(bus.boot_done), 32'(done));
        check({tag, "_err"},   32'(bus.boot_error), 32'(err));
        check({tag, "_words"}, 32'(bus.words_loaded), 32'(words));
    endtask

    task automatic basic_frame(input logic [7:0] c);
        hdr(16'd2);
        word(4'd0, 32'h0000_0013, 1'b1);
        word(4'd1, 32'h0010_0093, 1'b1);
        chk_byte(c);
        send_all();
        idle(3);
    endtask

    initial begin
        int got;
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        idle(3);
        check_reset_vals("reset");
        reset = 1'b0;
        idle(1);

        // Noise before any SYNC is ignored; no timer runs in IDLE.
        tx_q = '{8'h00, 8'hFF, 8'h5A};
        send_all();
        idle(120);
        check_status("noise", 1'b1, 1'b0, 1'b0, 0);

        // Basic two-word load, bytes back to back.
        basic_frame(8'h90);
        check_status("basic", 1'b0, 1'b1, 1'b0, 2);

        // DONE is terminal: a further frame is ignored.
        hdr(16'd1);
        word(4'd0, 32'h1111_2222, 1'b0);
        send_all();
        idle(3);
        check_status("done_sticky", 1'b0, 1'b1, 1'b0, 2);

`ifdef BOOT_CHECKSUM_EN
        // Bad checksum: writes still land, frame is rejected, then a good resend loads.
        do_reset();
        basic_frame(8'h91);
        check_status("badck", 1'b1, 1'b0, 1'b1, 2);
        basic_frame(8'h90);
        check_status("badck_resend", 1'b0, 1'b1, 1'b0, 2);
`endif

        // Oversize length (17 > 16 words) is rejected without writes.
        do_reset();
        tx_q = '{8'hA5, 8'h11, 8'h00};
        send_all();
        idle(2);
        check_status("oversize", 1'b1, 1'b0, 1'b1, 0);

        // Re-arm from ERROR with LEN = MAX_WORDS; data contains SYNC values.
        hdr(16'd16);
        for (int i = 0; i < 16; i++) begin
            word(4'(i), 32'hA500_A500 | (32'(i) << 16) | 32'(15 - i), 1'b1);
        end
        chk_byte(ck);
        send_all();
        idle(3);
        check_status("maxlen", 1'b0, 1'b1, 1'b0, 16);

        // Timeout: stall after one data byte.
        do_reset();
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h13};
        send_all();
        got = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (bus.boot_error === 1'b1) begin
                got = k;
                break;
            end
        end
        check("timeout_cycles", 32'(got), 32'd99);
        check_status("timeout", 1'b1, 1'b0, 1'b1, 0);

        // Reset in the middle of DATA after two words were written.
        do_reset();
        hdr(16'd3);
        word(4'd0, 32'h0000_0013, 1'b1);
        word(4'd1, 32'h0010_0093, 1'b1);
        tx_q.push_back(8'h77);
        send_all();
        check("middata_words", 32'(bus.words_loaded), 32'd2);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check_reset_vals("middata_reset");

        // Following full frame: single word, done right after its write.
        hdr(16'd1);
        word(4'd0, 32'hDEAD_BEEF, 1'b1);
`ifdef BOOT_CHECKSUM_EN
        send_all();
        check("deadbeef_we", 32'(bus.imem_we), 32'd1);
        send_byte(8'h22);
        check_status("deadbeef", 1'b0, 1'b1, 1'b0, 1);
`else
        send_all();
        check("deadbeef_we", 32'(bus.imem_we), 32'd1);
        check("deadbeef_done_early", 32'(bus.boot_done), 32'd0);
        idle(1);
        check_status("deadbeef", 1'b0, 1'b1, 1'b0, 1);
`endif

        // Zero-length frame.
        do_reset();
        hdr(16'd0);
        chk_byte(8'h00);
        send_all();
        idle(2);
        check_status("len0", 1'b0, 1'b1, 1'b0, 0);

        idle(5);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
